// File: rtl/fb_pkg.sv
// Framebuffer geometry and write-path types, shared by the pixel writer and
// the scan-out controller so both agree on word addressing and lane order.
package fb_pkg;

  localparam int FB_WIDTH        = 640;
  localparam int FB_HEIGHT       = 480;
  localparam int PIX_PER_WORD    = 4;
  localparam int WORDS_PER_FRAME = (FB_WIDTH * FB_HEIGHT) / PIX_PER_WORD;
  localparam int FB_ADDR_W       = 19;

  // Byte lane inside a 32-bit framebuffer word; pixel k lives in byte k.
  typedef logic [1:0] lane_t;

  // Write slot: idle, or holding a word until the memory acks it.
  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_REQ  = 1'b1
  } wstate_t;

  // One-hot byte-enable bit for a lane.
  function automatic logic [3:0] lane_bit(input lane_t l);
    return 4'b0001 << l;
  endfunction

endpackage

// File: rtl/fb_pixel_writer.sv
// Packs a stream of 8-bit palette indices four per 32-bit word and writes the
// words into the framebuffer, using the same word addressing and lane order
// as the scan-out side. Partial words are written on SOF or an explicit flush.
//
// Pixel handshake: a pixel transfers on a rising iCLK edge where
// iPIX_VALID && oPIX_READY; the producer holds iPIX_DATA/iPIX_SOF stable while
// iPIX_VALID is high and not yet accepted. Memory handshake: oWR_EN with
// oWR_ADDR/oWR_DATA/oWR_BE stay asserted and unchanged until an edge where
// oWR_EN && iWR_ACK; the write completes on that edge.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int WORDS_PER_FRAME = fb_pkg::WORDS_PER_FRAME,
  parameter int ADDR_W          = fb_pkg::FB_ADDR_W
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iPIX_VALID,
  input  logic [7:0]        iPIX_DATA,
  input  logic              iPIX_SOF,
  output logic              oPIX_READY,
  input  logic              iFLUSH,
  output logic              oWR_EN,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic [31:0]       oWR_DATA,
  output logic [3:0]        oWR_BE,
  input  logic              iWR_ACK,
  output logic              oFRAME_DONE,
  output logic              oDBG_WSTATE
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_FRAME - 1);

  // Word address after a, wrapping at the end of the frame.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // Packer state
  lane_t             lane_q, lane_d;
  logic [31:0]       pack_q, pack_d;
  logic [3:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              flush_pend_q, flush_pend_d;

  // Write slot state
  wstate_t           wstate_q, wstate_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [3:0]        wr_be_q, wr_be_d;
  logic              frame_done_q, frame_done_d;

  logic              slot_busy;
  logic              pix_ready;
  logic              pix_acc;
  logic              acked;
  logic              load;
  logic              flush_want;
  logic [31:0]       pix_word;

  // Handshake qualifiers: stall only when an accepted pixel would need the
  // slot (word completion or SOF split) while it still holds a word.
  always_comb begin
    slot_busy = (wstate_q == W_REQ);
    pix_ready = !flush_pend_q
              && !(lane_q == 2'd3 && slot_busy)
              && !(iPIX_SOF && lane_q != 2'd0 && slot_busy);
    pix_acc   = iPIX_VALID && pix_ready;
    acked     = slot_busy && iWR_ACK;
    pix_word  = 32'(iPIX_DATA) << {lane_q, 3'b000};
  end

  // Next-state: pack the accepted pixel first, then service any flush with
  // the post-pixel packer contents, then drive the slot.
  always_comb begin
    lane_d       = lane_q;
    pack_d       = pack_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    flush_pend_d = flush_pend_q;
    wstate_d     = wstate_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_be_d      = wr_be_q;
    load         = 1'b0;
    flush_want   = flush_pend_q || (iFLUSH && lane_q != 2'd0);
    frame_done_d = acked && (wr_addr_q == LAST_ADDR) && (wr_be_q == 4'hF);

    if (acked) begin
      wstate_d = W_IDLE;
    end

    if (pix_acc) begin
      if (iPIX_SOF) begin
        // Close out any partial word at its own address, then restart at 0.
        if (lane_q != 2'd0) begin
          wr_addr_d = addr_q;
          wr_data_d = pack_q;
          wr_be_d   = mask_q;
          load      = 1'b1;
        end
        pack_d = {24'h0, iPIX_DATA};
        mask_d = 4'b0001;
        lane_d = 2'd1;
        addr_d = '0;
      end else if (lane_q == 2'd3) begin
        wr_addr_d = addr_q;
        wr_data_d = pack_q | pix_word;
        wr_be_d   = 4'hF;
        load      = 1'b1;
        pack_d    = '0;
        mask_d    = '0;
        lane_d    = 2'd0;
        addr_d    = next_addr(addr_q);
      end else begin
        pack_d = pack_q | pix_word;
        mask_d = mask_q | lane_bit(lane_q);
        lane_d = lane_q + 2'd1;
      end
    end

    if (flush_want) begin
      if (lane_d == 2'd0) begin
        // Nothing left to flush (or the pixel just completed the word).
        flush_pend_d = 1'b0;
      end else if (!slot_busy && !load) begin
        wr_addr_d    = addr_d;
        wr_data_d    = pack_d;
        wr_be_d      = mask_d;
        load         = 1'b1;
        pack_d       = '0;
        mask_d       = '0;
        lane_d       = 2'd0;
        addr_d       = next_addr(addr_d);
        flush_pend_d = 1'b0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end

    if (load) begin
      wstate_d = W_REQ;
    end
  end

  // State registers; reset abandons any word held in the slot.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      lane_q       <= 2'd0;
      pack_q       <= '0;
      mask_q       <= '0;
      addr_q       <= '0;
      flush_pend_q <= 1'b0;
      wstate_q     <= W_IDLE;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_be_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      flush_pend_q <= flush_pend_d;
      wstate_q     <= wstate_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_be_q      <= wr_be_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign oPIX_READY  = pix_ready;
  assign oWR_EN      = (wstate_q == W_REQ);
  assign oWR_ADDR    = wr_addr_q;
  assign oWR_DATA    = wr_data_q;
  assign oWR_BE      = wr_be_q;
  assign oFRAME_DONE = frame_done_q;
  assign oDBG_WSTATE = wstate_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: packing, ack stalls, flush, SOF split,
// frame wrap with done pulse, and reset while a write is pending.
module tb_fb_pixel_writer;

  localparam int WPF = 24;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_sof;
  logic        pix_ready;
  logic        flush;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        wr_ack;
  logic        frame_done;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  fb_pixel_writer #(.WORDS_PER_FRAME(WPF), .ADDR_W(19)) dut (
    .iCLK        (clk),
    .iRST_n      (rst_n),
    .iPIX_VALID  (pix_valid),
    .iPIX_DATA   (pix_data),
    .iPIX_SOF    (pix_sof),
    .oPIX_READY  (pix_ready),
    .iFLUSH      (flush),
    .oWR_EN      (wr_en),
    .oWR_ADDR    (wr_addr),
    .oWR_DATA    (wr_data),
    .oWR_BE      (wr_be),
    .iWR_ACK     (wr_ack),
    .oFRAME_DONE (frame_done),
    .oDBG_WSTATE (dbg_state)
  );

  // Write capture: every completed memory write, in order
  logic [18:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  wb_q[$];
  int          fd_cyc[$];
  int          last_ack_cyc = -1;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && wr_en && wr_ack) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wb_q.push_back(wr_be);
      if (wr_addr == 19'(WPF - 1) && wr_be == 4'hF) last_ack_cyc = cyc;
    end
    if (frame_done) fd_cyc.push_back(cyc);
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    pix_sof   = 1'b0;
    flush     = 1'b0;
    wr_ack    = 1'b0;
    repeat (2) @(posedge clk);
    wa_q.delete();
    wd_q.delete();
    wb_q.delete();
    fd_cyc.delete();
    last_ack_cyc = -1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic send_pix(input logic [7:0] d, input logic sof, input logic fl,
                          output int stalls);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    flush     = fl;
    stalls    = 0;
    forever begin
      @(negedge clk);
      if (pix_ready) break;
      stalls++;
      if (stalls > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: pixel %h not accepted after %0d cycles, expected acceptance", d, stalls);
        break;
      end
    end
    @(posedge clk);
    #2;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while (wa_q.size() < n && t < 300) begin
      step();
      t++;
    end
    checks++;
    if (wa_q.size() < n) begin
      errors++;
      $display("FAIL write_count: got %0d writes, expected at least %0d", wa_q.size(), n);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    pix_sof   = 1'b0;
    flush     = 1'b0;
    wr_ack    = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    checks++; if (wr_addr !== 19'd0) begin errors++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
    checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    checks++; if (wr_be !== 4'd0) begin errors++; $display("FAIL reset_wr_be: got %h expected 0", wr_be); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    rst_n = 1'b1;
    step();
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", pix_ready); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", dbg_state); end
  endtask

  task automatic test_basic();
    int st;
    int total = 0;
    do_reset();
    wr_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_pix(8'(8'h10 + i), 1'b0, 1'b0, st);
      total += st;
    end
    wait_writes(2);
    checks++; if (total !== 0) begin errors++; $display("FAIL basic_stalls: got %0d stall cycles expected 0", total); end
    if (wa_q.size() >= 2) begin
      checks++; if (wa_q[0] !== 19'd0) begin errors++; $display("FAIL basic_addr0: got %h expected 0", wa_q[0]); end
      checks++; if (wd_q[0] !== 32'h13121110) begin errors++; $display("FAIL basic_data0: got %h expected 13121110", wd_q[0]); end
      checks++; if (wb_q[0] !== 4'hF) begin errors++; $display("FAIL basic_be0: got %h expected f", wb_q[0]); end
      checks++; if (wa_q[1] !== 19'd1) begin errors++; $display("FAIL basic_addr1: got %h expected 1", wa_q[1]); end
      checks++; if (wd_q[1] !== 32'h17161514) begin errors++; $display("FAIL basic_data1: got %h expected 17161514", wd_q[1]); end
      checks++; if (wb_q[1] !== 4'hF) begin errors++; $display("FAIL basic_be1: got %h expected f", wb_q[1]); end
    end
  endtask

  task automatic test_stall();
    int st_arr[12];
    int others = 0;
    do_reset();
    wr_ack = 1'b0;
    fork
      begin
        int st;
        for (int i = 0; i < 12; i++) begin
          send_pix(8'(8'h20 + i), 1'b0, 1'b0, st);
          st_arr[i] = st;
        end
      end
      begin
        int n = 0;
        while (!wr_en && n < 50) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if (!wr_en) begin errors++; $display("FAIL stall_wr_en: got 0 expected 1 within 50 cycles"); end
        repeat (10) begin
          @(negedge clk);
          checks++;
          if (wr_en !== 1'b1 || wr_addr !== 19'd0 || wr_data !== 32'h23222120 || wr_be !== 4'hF) begin
            errors++;
            $display("FAIL stall_hold: got en=%b addr=%h data=%h be=%h expected en=1 addr=0 data=23222120 be=f",
                     wr_en, wr_addr, wr_data, wr_be);
          end
        end
        @(posedge clk);
        #2;
        wr_ack = 1'b1;
      end
    join
    for (int i = 0; i < 12; i++) if (i != 7) others += st_arr[i];
    checks++; if (st_arr[7] <= 0) begin errors++; $display("FAIL stall_lane3: got %0d stall cycles on pixel 7 expected >0", st_arr[7]); end
    checks++; if (others !== 0) begin errors++; $display("FAIL stall_others: got %0d stall cycles on other pixels expected 0", others); end
    wait_writes(3);
    if (wa_q.size() >= 3) begin
      checks++; if (wa_q[0] !== 19'd0 || wd_q[0] !== 32'h23222120) begin errors++; $display("FAIL stall_word0: got %h/%h expected 0/23222120", wa_q[0], wd_q[0]); end
      checks++; if (wa_q[1] !== 19'd1 || wd_q[1] !== 32'h27262524) begin errors++; $display("FAIL stall_word1: got %h/%h expected 1/27262524", wa_q[1], wd_q[1]); end
      checks++; if (wa_q[2] !== 19'd2 || wd_q[2] !== 32'h2B2A2928) begin errors++; $display("FAIL stall_word2: got %h/%h expected 2/2b2a2928", wa_q[2], wd_q[2]); end
    end
  endtask

  task automatic test_flush();
    int st;
    do_reset();
    wr_ack = 1'b1;
    send_pix(8'hA0, 1'b0, 1'b0, st);
    send_pix(8'hA1, 1'b0, 1'b0, st);
    send_pix(8'hA2, 1'b0, 1'b0, st);
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) step();
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", pix_ready); end
    for (int i = 0; i < 4; i++) send_pix(8'(8'hB0 + i), 1'b0, 1'b0, st);
    wait_writes(2);
    if (wa_q.size() >= 2) begin
      checks++; if (wa_q[0] !== 19'd0) begin errors++; $display("FAIL flush_addr: got %h expected 0", wa_q[0]); end
      checks++; if (wd_q[0] !== 32'h00A2A1A0) begin errors++; $display("FAIL flush_data: got %h expected 00a2a1a0", wd_q[0]); end
      checks++; if (wb_q[0] !== 4'b0111) begin errors++; $display("FAIL flush_be: got %b expected 0111", wb_q[0]); end
      checks++; if (wa_q[1] !== 19'd1 || wd_q[1] !== 32'hB3B2B1B0 || wb_q[1] !== 4'hF) begin
        errors++; $display("FAIL flush_next: got %h/%h/%h expected 1/b3b2b1b0/f", wa_q[1], wd_q[1], wb_q[1]);
      end
    end
  endtask

  task automatic test_sof();
    int st;
    do_reset();
    wr_ack = 1'b1;
    for (int i = 0; i < 20; i++) send_pix(8'(i), 1'b0, 1'b0, st);
    send_pix(8'hC0, 1'b0, 1'b0, st);
    send_pix(8'hC1, 1'b0, 1'b0, st);
    send_pix(8'h55, 1'b1, 1'b0, st);
    send_pix(8'h56, 1'b0, 1'b0, st);
    send_pix(8'h57, 1'b0, 1'b0, st);
    send_pix(8'h58, 1'b0, 1'b0, st);
    wait_writes(7);
    repeat (3) step();
    checks++; if (wa_q.size() !== 7) begin errors++; $display("FAIL sof_count: got %0d writes expected 7", wa_q.size()); end
    if (wa_q.size() >= 7) begin
      checks++; if (wa_q[4] !== 19'd4 || wd_q[4] !== 32'h13121110) begin errors++; $display("FAIL sof_word4: got %h/%h expected 4/13121110", wa_q[4], wd_q[4]); end
      checks++; if (wa_q[5] !== 19'd5) begin errors++; $display("FAIL sof_part_addr: got %h expected 5", wa_q[5]); end
      checks++; if (wd_q[5] !== 32'h0000C1C0) begin errors++; $display("FAIL sof_part_data: got %h expected 0000c1c0", wd_q[5]); end
      checks++; if (wb_q[5] !== 4'b0011) begin errors++; $display("FAIL sof_part_be: got %b expected 0011", wb_q[5]); end
      checks++; if (wa_q[6] !== 19'd0 || wd_q[6] !== 32'h58575655 || wb_q[6] !== 4'hF) begin
        errors++; $display("FAIL sof_new_word: got %h/%h/%h expected 0/58575655/f", wa_q[6], wd_q[6], wb_q[6]);
      end
    end
  endtask

  task automatic test_frame();
    int st;
    do_reset();
    wr_ack = 1'b1;
    for (int i = 0; i < (WPF + 1) * 4; i++) send_pix(8'(i), 1'b0, 1'b0, st);
    wait_writes(WPF + 1);
    repeat (3) step();
    if (wa_q.size() >= WPF + 1) begin
      checks++; if (wa_q[WPF-1] !== 19'(WPF - 1) || wd_q[WPF-1] !== 32'h5F5E5D5C) begin
        errors++; $display("FAIL frame_last: got %h/%h expected %h/5f5e5d5c", wa_q[WPF-1], wd_q[WPF-1], WPF - 1);
      end
      checks++; if (wa_q[WPF] !== 19'd0 || wd_q[WPF] !== 32'h63626160) begin
        errors++; $display("FAIL frame_wrap: got %h/%h expected 0/63626160", wa_q[WPF], wd_q[WPF]);
      end
    end
    checks++; if (fd_cyc.size() !== 1) begin errors++; $display("FAIL frame_done_count: got %0d pulse cycles expected 1", fd_cyc.size()); end
    if (fd_cyc.size() >= 1) begin
      checks++; if (fd_cyc[0] !== last_ack_cyc + 1) begin
        errors++; $display("FAIL frame_done_time: got cycle %0d expected %0d", fd_cyc[0], last_ack_cyc + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int st;
    int n = 0;
    do_reset();
    wr_ack = 1'b0;
    for (int i = 0; i < 4; i++) send_pix(8'(8'h60 + i), 1'b0, 1'b0, st);
    while (!wr_en && n < 20) begin
      step();
      n++;
    end
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b expected 1", wr_en); end
    rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL mid_async_drop: got %b expected 0", wr_en); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL mid_state: got %b expected 0", dbg_state); end
    step();
    rst_n  = 1'b1;
    wr_ack = 1'b1;
    for (int i = 0; i < 4; i++) send_pix(8'(8'h70 + i), 1'b0, 1'b0, st);
    wait_writes(1);
    repeat (2) step();
    checks++; if (wa_q.size() !== 1) begin errors++; $display("FAIL mid_count: got %0d writes expected 1", wa_q.size()); end
    if (wa_q.size() >= 1) begin
      checks++; if (wa_q[0] !== 19'd0 || wd_q[0] !== 32'h73727170) begin
        errors++; $display("FAIL mid_first: got %h/%h expected 0/73727170", wa_q[0], wd_q[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_sof();
    test_frame();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Write-side counterpart of the VGA scan-out path: accepts a stream of 8-bit palette indices, packs four per 32-bit word, and issues word writes into the framebuffer memory that the display controller reads. Word addressing and lane order match the scan-out side exactly: one 19-bit word address per four pixels, and pixel k of a word in byte k. Sits between the pixel producer (renderer/DMA) and the framebuffer RAM write port.

## Interface
- WORDS_PER_FRAME, 76800, words per frame (640x480/4); word address wraps to 0 after WORDS_PER_FRAME-1
- ADDR_W, 19, word address width
- iCLK  in  1  system clock
- iRST_n  in  1  reset; **asynchronous, active-low**; one clock domain
- iPIX_VALID  in  1  pixel present
- iPIX_DATA  in  8  palette index
- iPIX_SOF  in  1  qualifies the pixel as the first of a frame
- oPIX_READY  out  1  pixel accepted when iPIX_VALID && oPIX_READY
- iFLUSH  in  1  single-cycle pulse; write out any partial word
- oWR_EN  out  1  write request, held until acked
- oWR_ADDR  out  ADDR_W  word address
- oWR_DATA  out  32  packed pixels, lane k = bits [8k+7:8k]
- oWR_BE  out  4  byte enables, bit k = lane k valid
- iWR_ACK  in  1  memory accepts the write in the cycle where oWR_EN && iWR_ACK
- oFRAME_DONE  out  1  one-cycle pulse when word WORDS_PER_FRAME-1 is acked

## Operation
- Packer: 2-bit lane counter, 32-bit pack register, 4-bit valid mask. Accepted pixel goes to lane `lane`; lane increments, wrapping 3->0.
- Write slot: FSM W_IDLE/W_REQ. Loading the slot sets oWR_EN/ADDR/DATA/BE and moves to W_REQ. W_REQ -> W_IDLE on iWR_ACK. ADDR/DATA/BE are stable while in W_REQ.
- Word completion: accepting the lane-3 pixel loads the slot with BE=4'b1111. The word address counter increments modulo WORDS_PER_FRAME.
- SOF:
  - With lane==0: the pixel is written to lane 0 and the next word address is forced to 0.
  - With lane!=0: the partial word is loaded into the slot (BE = valid mask) at the current address. The SOF pixel then starts a new word at lane 0, address 0.
- iFLUSH with lane!=0:
  - Sets flush_pending.
  - When the slot is free, loads the partial word with BE = mask, clears lane and mask, and increments the address.
  - iFLUSH with lane==0 is a no-op.
- oPIX_READY = 0 in any of these cases:
  - flush_pending
  - lane==3 && oWR_EN
  - iPIX_SOF && lane!=0 && oWR_EN (combinational on iPIX_SOF)
- Otherwise oPIX_READY = 1.
- Simultaneous iFLUSH and an accepted pixel: the pixel is packed first. If it completes the word, the flush is satisfied by that word.

## Timing
- Reset values:
  - oWR_EN=0, oWR_ADDR=0, oWR_DATA=0, oWR_BE=0, oFRAME_DONE=0.
  - Lane=0, address counter=0, FSM=W_IDLE.
  - oPIX_READY=1 once reset deasserts; nothing is accepted while iRST_n=0.
- Latency: lane-3 pixel accepted at edge t gives oWR_EN=1 from t+1.
- Ack: oWR_EN=1 && iWR_ACK=1 at edge t gives oWR_EN=0 from t+1. The earliest ack is the first cycle of oWR_EN.
- Full rate (one pixel/cycle) is sustained if every ack arrives within 3 cycles of oWR_EN rising. Otherwise ready stalls only on lane 3.
- oFRAME_DONE is high the cycle after the ack of the address WORDS_PER_FRAME-1 write with BE=4'b1111.
- Reset mid-request: oWR_EN drops asynchronously and the pending word is discarded. The memory must tolerate an abandoned request.

## Structure
- Shared package fb_pkg:
  - FB_WIDTH=640, FB_HEIGHT=480, PIX_PER_WORD=4, WORDS_PER_FRAME, FB_ADDR_W=19
  - typedef lane_t (2 bits), typedef wstate_t {W_IDLE, W_REQ}
- The scan-out side imports the same constants.
- No sub-module required. The packer and write slot fit in one module (~200 lines).

## Test plan
- Reset, then 8 pixels 0x10..0x17 with iWR_ACK tied high -> two writes:
  - addr 0, data 0x13121110, BE 4'hF
  - addr 1, data 0x17161514, BE 4'hF
  - ready never drops.
- iWR_ACK held low for 10 cycles after the first word, pixels continuous -> ready drops on lane 3 of word 2. No pixel is lost; word 1 data and address stay stable until the ack.
- 3 pixels 0xA0..0xA2 then iFLUSH -> write addr 0, data 0x00A2A1A0, BE 4'b0111. The next full word goes to addr 1.
- 2 pixels then an SOF pixel 0x55 at address 5 -> partial write at addr 5, BE 4'b0011. The following word is at addr 0 with lane 0 = 0x55.
- Stream WORDS_PER_FRAME*4 pixels -> last write at addr 76799, oFRAME_DONE pulses for one cycle, and the next word wraps to addr 0.
- Assert iRST_n low while oWR_EN=1 -> oWR_EN is 0 immediately. After release the first write goes to addr 0.
